// File: rtl/regarray_pkg.sv
// Shared sizing helpers and default-configuration types for the register-array FIFO.
package regarray_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 8;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W = ptr_width(DEFAULT_DEPTH);
  localparam int CNT_W = cnt_width(DEFAULT_DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/regarray_ptr.sv
// Wrapping FIFO pointer: synchronous reset/clear to zero, increments modulo 2**PTR_W.
module regarray_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/regarray_fifo.sv
// First-word-fall-through FIFO on a flip-flop register array with explicit occupancy count.
// Optional head-relative peek port enabled by defining REGARRAY_FIFO_PEEK_EN.
module regarray_fifo
  import regarray_pkg::*;
#(
  parameter  int WIDTH   = DEFAULT_WIDTH,
  parameter  int DEPTH   = DEFAULT_DEPTH,
  localparam int ADDR_W  = ptr_width(DEPTH),
  localparam int COUNT_W = cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] count
`ifdef REGARRAY_FIFO_PEEK_EN
  ,
  input  logic [ADDR_W-1:0]  peek_addr,
  output logic [WIDTH-1:0]   peek_data,
  output logic               peek_valid
`endif
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               push;
  logic               pop;

  assign in_ready  = (count_q != COUNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;
  assign out_data  = mem_q[rd_ptr];

  regarray_ptr #(.PTR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc_i (push),
    .ptr_o (wr_ptr)
  );

  regarray_ptr #(.PTR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc_i (pop),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + COUNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Clear flushes pointers only; stored words survive, so a push in that cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !clear) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

`ifdef REGARRAY_FIFO_PEEK_EN
  logic [ADDR_W-1:0] peek_ptr;

  assign peek_ptr   = rd_ptr + peek_addr;
  assign peek_data  = mem_q[peek_ptr];
  assign peek_valid = ({1'b0, peek_addr} < count_q);
`endif

endmodule

// File: tb/tb_regarray_fifo.sv
// Self-checking bench for regarray_fifo: table-driven vectors plus a data scoreboard queue.
module tb_regarray_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [3:0] count;
`ifdef REGARRAY_FIFO_PEEK_EN
  logic [2:0] peek_addr = 3'd0;
  logic [3:0] peek_data;
  logic       peek_valid;
`endif

  always #5 clk = ~clk;

  regarray_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
`ifdef REGARRAY_FIFO_PEEK_EN
    ,
    .peek_addr (peek_addr),
    .peek_data (peek_data),
    .peek_valid(peek_valid)
`endif
  );

  typedef struct {
    logic       iv;
    logic [3:0] din;
    logic       ordy;
    logic       clr;
    int         exp_cnt;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         txn = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge; checks pre-edge state, updates the model, then steps one cycle.
  task automatic drive(input logic iv, input logic [3:0] d, input logic ordy,
                       input logic clr, input int exp_cnt);
    logic [3:0] e;
    bit         full;
    bit         empty;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    full      = (sb.size() == DEPTH);
    empty     = (sb.size() == 0);
    chk("in_ready", int'(in_ready), int'(!full));
    chk("out_valid", int'(out_valid), int'(!empty));
    if (clr) begin
      sb.delete();
    end else begin
      if (!empty && ordy) begin
        e = sb.pop_front();
        chk("out_data", int'(out_data), int'(e));
      end
      if (iv && !full) sb.push_back(d);
    end
    @(negedge clk);
    chk("count", int'(count), exp_cnt);
    $display("txn %0d: iv=%0b din=%h ordy=%0b clr=%0b -> count=%0d", txn, iv, d, ordy, clr, count);
    txn++;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].clr, vecs[i].exp_cnt);
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and idle.
    do_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
`ifdef REGARRAY_FIFO_PEEK_EN
    #1;
    chk("rst_peek_data", int'(peek_data), 0);
    chk("rst_peek_valid", int'(peek_valid), 0);
`endif
    drive(1'b0, 4'h0, 1'b0, 1'b0, 0);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 0);

    // Fill to full, ninth push refused, drain in order.
    for (int i = 1; i <= 8; i++) vecs.push_back('{1'b1, 4'(i), 1'b0, 1'b0, i});
    vecs.push_back('{1'b1, 4'h9, 1'b0, 1'b0, 8});
    for (int i = 1; i <= 8; i++) vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 8 - i});
    run_vecs();

    // Full with push+pop requested together: only the pop happens.
    for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, 4'(i + 3), 1'b0, 1'b0, i + 1});
    vecs.push_back('{1'b1, 4'hE, 1'b1, 1'b0, 7});
    for (int i = 1; i <= 7; i++) vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 7 - i});
    run_vecs();

    // Steady state at count 3 with a push and pop every cycle; data wraps mod 16.
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b1, 4'(i), 1'b0, 1'b0, i + 1});
    for (int i = 0; i < 20; i++) vecs.push_back('{1'b1, 4'((i + 3) % 16), 1'b1, 1'b0, 3});
    for (int i = 1; i <= 3; i++) vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 3 - i});
    run_vecs();

    // Clear with a concurrent push discards the word; next push lands at the head.
    drive(1'b1, 4'h5, 1'b0, 1'b0, 1);
    drive(1'b1, 4'h6, 1'b0, 1'b0, 2);
    drive(1'b1, 4'h7, 1'b0, 1'b0, 3);
    drive(1'b1, 4'h9, 1'b1, 1'b1, 0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 0);
    drive(1'b1, 4'hA, 1'b0, 1'b0, 1);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 0);

    // Reset mid-fill zeroes every array entry.
    for (int i = 1; i <= 5; i++) drive(1'b1, 4'(i), 1'b0, 1'b0, i);
    in_valid = 1'b1;
    in_data  = 4'h3;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("midrst_count", int'(count), 0);
    chk("midrst_out_data", int'(out_data), 0);
`ifdef REGARRAY_FIFO_PEEK_EN
    for (int a = 0; a < DEPTH; a++) begin
      peek_addr = 3'(a);
      #1;
      chk("midrst_peek_data", int'(peek_data), 0);
      chk("midrst_peek_valid", int'(peek_valid), 0);
    end
    peek_addr = 3'd0;
`endif
    // Each push-then-pop advances the head onto an entry untouched since reset.
    for (int k = 1; k < DEPTH; k++) begin
      drive(1'b1, 4'hF, 1'b0, 1'b0, 1);
      drive(1'b0, 4'h0, 1'b1, 1'b0, 0);
      chk("stale_out_valid", int'(out_valid), 0);
      chk("stale_out_data", int'(out_data), 0);
    end

`ifdef REGARRAY_FIFO_PEEK_EN
    // Peek with head at address 1.
    do_reset();
    drive(1'b1, 4'h1, 1'b0, 1'b0, 1);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 0);
    drive(1'b1, 4'hA, 1'b0, 1'b0, 1);
    drive(1'b1, 4'hB, 1'b0, 1'b0, 2);
    drive(1'b1, 4'hC, 1'b0, 1'b0, 3);
    peek_addr = 3'd0;
    #1;
    chk("peek0_data", int'(peek_data), 10);
    chk("peek0_valid", int'(peek_valid), 1);
    peek_addr = 3'd2;
    #1;
    chk("peek2_data", int'(peek_data), 12);
    chk("peek2_valid", int'(peek_valid), 1);
    peek_addr = 3'd3;
    #1;
    chk("peek3_valid", int'(peek_valid), 0);
    peek_addr = 3'd0;
    for (int i = 1; i <= 3; i++) drive(1'b0, 4'h0, 1'b1, 1'b0, 3 - i);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
